// File: rtl/instruction_set.sv
// Shared core definitions: word/memory sizes, memory request opcodes and
// the data-memory controller's MMIO offsets and state encoding.
package instruction_set;

    localparam int WORD_SIZE     = 8;
    localparam int DATA_MEM_SIZE = 128;

    // Encoding 2'd3 is reserved and never accepted by the memory controller.
    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } MEM_OPS_T;

    localparam logic [WORD_SIZE-1:0] MMIO_GPIO_OUT = 8'h00;
    localparam logic [WORD_SIZE-1:0] MMIO_GPIO_IN  = 8'h01;
    localparam logic [WORD_SIZE-1:0] MMIO_TIMER    = 8'h02;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } MEM_CTRL_STATE_T;

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous RAM, write-first not required: read data is the
// pre-write contents, one cycle after the address is presented.
module data_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: services single MEM_READ/MEM_WRITE requests into a
// RAM plus a GPIO/timer MMIO window, answering with a one-cycle mem_ready.
//
// Handshake: a request is taken in IDLE when mem_op is READ/WRITE and the
// controller is armed; arming needs one sampled MEM_NOP since the last accept,
// so a held request runs once. mem_ready pulses two cycles after accept, with
// mem_rdata/mem_err valid in that same cycle.
module data_mem_ctrl
    import instruction_set::*;
#(
    parameter logic [WORD_SIZE-1:0] MMIO_BASE = 8'hF0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mem_op,
    input  logic [WORD_SIZE-1:0] mem_rw_addr,
    input  logic [WORD_SIZE-1:0] mem_wdata,
    output logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 mem_ready,
    output logic                 mem_err,
    input  logic [WORD_SIZE-1:0] gpio_in,
    output logic [WORD_SIZE-1:0] gpio_out,
    output MEM_CTRL_STATE_T      dbg_state
);

    localparam int RAM_AW = $clog2(DATA_MEM_SIZE);
    localparam logic [WORD_SIZE-1:0] ADDR_GPO = MMIO_BASE + MMIO_GPIO_OUT;
    localparam logic [WORD_SIZE-1:0] ADDR_GPI = MMIO_BASE + MMIO_GPIO_IN;
    localparam logic [WORD_SIZE-1:0] ADDR_TMR = MMIO_BASE + MMIO_TIMER;

    MEM_CTRL_STATE_T state, state_next;

    logic                 armed;
    logic [1:0]           op_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] timer;
    logic [WORD_SIZE-1:0] gpio_sync1;
    logic [WORD_SIZE-1:0] gpio_sync2;

    logic                 accept;
    logic                 is_write;
    logic                 sel_ram, sel_gpo, sel_gpi, sel_tmr;
    logic                 acc_err;
    logic [WORD_SIZE-1:0] rd_val;
    logic                 ram_we;
    logic [RAM_AW-1:0]    ram_addr;
    logic [WORD_SIZE-1:0] ram_rdata;

    assign accept    = (state == IDLE) && armed &&
                       ((mem_op == MEM_READ) || (mem_op == MEM_WRITE));
    assign is_write  = (op_q == MEM_WRITE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_ram = (int'(addr_q) < DATA_MEM_SIZE);
        sel_gpo = (addr_q == ADDR_GPO);
        sel_gpi = (addr_q == ADDR_GPI);
        sel_tmr = (addr_q == ADDR_TMR);
        rd_val  = '0;
        acc_err = 1'b0;
        if (is_write) begin
            // GPIO_IN is read-only, so a write there is reported like unmapped.
            acc_err = !(sel_ram || sel_gpo || sel_tmr);
        end else if (sel_ram) begin
            rd_val = ram_rdata;
        end else if (sel_gpo) begin
            rd_val = gpio_out;
        end else if (sel_gpi) begin
            rd_val = gpio_sync2;
        end else if (sel_tmr) begin
            rd_val = timer;
        end else begin
            acc_err = 1'b1;
        end
    end

    // The RAM address follows the live request in IDLE so read data is
    // already out of the RAM while ACCESS is in progress.
    assign ram_addr = (state == IDLE) ? mem_rw_addr[RAM_AW-1:0] : addr_q[RAM_AW-1:0];
    assign ram_we   = (state == ACCESS) && is_write && sel_ram && !reset;

    data_ram #(
        .WIDTH (WORD_SIZE),
        .DEPTH (DATA_MEM_SIZE),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            armed   <= 1'b1;
            op_q    <= MEM_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (mem_op == MEM_NOP) begin
                armed <= 1'b1;
            end else if (accept) begin
                armed <= 1'b0;
            end
            if (accept) begin
                op_q    <= mem_op;
                addr_q  <= mem_rw_addr;
                wdata_q <= mem_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rdata  <= '0;
            mem_ready  <= 1'b0;
            mem_err    <= 1'b0;
            gpio_out   <= '0;
            timer      <= '0;
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
            mem_ready  <= (state == ACCESS);
            mem_err    <= (state == ACCESS) && acc_err;
            if ((state == ACCESS) && !is_write) begin
                mem_rdata <= rd_val;
            end
            if ((state == ACCESS) && is_write && sel_gpo) begin
                gpio_out <= wdata_q;
            end
            if ((state == ACCESS) && is_write && sel_tmr) begin
                timer <= wdata_q;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: RAM, MMIO, held-request, timer and
// reset-during-access scenarios with hand-computed expectations.
module tb_data_mem_ctrl;
    import instruction_set::*;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      mem_op;
    logic [7:0]      mem_rw_addr;
    logic [7:0]      mem_wdata;
    logic [7:0]      mem_rdata;
    logic            mem_ready;
    logic            mem_err;
    logic [7:0]      gpio_in;
    logic [7:0]      gpio_out;
    MEM_CTRL_STATE_T dbg_state;

    int         checks = 0;
    int         errors = 0;
    int         ready_cnt;
    int         cyc_in_req;
    int         cap_cycle;
    logic [7:0] cap_rdata;
    logic       cap_err;

    data_mem_ctrl #(.MMIO_BASE(8'hF0)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_op      (mem_op),
        .mem_rw_addr (mem_rw_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .mem_err     (mem_err),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_in_req++;
        if (mem_ready === 1'b1) begin
            ready_cnt++;
            cap_rdata = mem_rdata;
            cap_err   = mem_err;
            cap_cycle = cyc_in_req;
        end
    endtask

    task automatic start_req();
        ready_cnt  = 0;
        cyc_in_req = 0;
        cap_cycle  = 0;
        cap_rdata  = 8'h00;
        cap_err    = 1'b0;
    endtask

    task automatic req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                       input int hold);
        start_req();
        mem_op      = op;
        mem_rw_addr = a;
        mem_wdata   = d;
        repeat (hold) tick();
        mem_op = MEM_NOP;
        repeat (2) tick();
    endtask

    initial begin
        reset       = 1'b1;
        mem_op      = MEM_NOP;
        mem_rw_addr = 8'h00;
        mem_wdata   = 8'h00;
        gpio_in     = 8'h00;
        start_req();
        repeat (2) tick();
        check("rst_rdata", 32'(mem_rdata), 32'h00);
        check("rst_ready", 32'(mem_ready), 32'h0);
        check("rst_err", 32'(mem_err), 32'h0);
        check("rst_gpio_out", 32'(gpio_out), 32'h00);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        tick();

        // Held write then read back.
        req(MEM_WRITE, 8'h05, 8'hA5, 4);
        check("wr05_readies", 32'(ready_cnt), 32'd1);
        check("wr05_latency", 32'(cap_cycle), 32'd2);
        check("wr05_err", 32'(cap_err), 32'h0);
        req(MEM_READ, 8'h05, 8'h00, 3);
        check("rd05_readies", 32'(ready_cnt), 32'd1);
        check("rd05_latency", 32'(cap_cycle), 32'd2);
        check("rd05_data", 32'(cap_rdata), 32'hA5);
        check("rd05_err", 32'(cap_err), 32'h0);

        // Write held 6 cycles, data changed mid-hold, no re-accept without NOP.
        start_req();
        mem_op      = MEM_WRITE;
        mem_rw_addr = 8'h06;
        mem_wdata   = 8'h5A;
        repeat (2) tick();
        mem_wdata = 8'h11;
        repeat (4) tick();
        check("hold_readies", 32'(ready_cnt), 32'd1);
        check("hold_idle", 32'(dbg_state), 32'(IDLE));
        mem_op = MEM_NOP;
        tick();
        req(MEM_READ, 8'h06, 8'h00, 3);
        check("hold_data", 32'(cap_rdata), 32'h5A);

        // Reserved op does not re-arm.
        start_req();
        mem_op = MEM_READ;
        repeat (3) tick();
        mem_op = 2'd3;
        repeat (2) tick();
        mem_op = MEM_READ;
        repeat (3) tick();
        check("rsv_no_rearm", 32'(ready_cnt), 32'd1);
        mem_op = MEM_NOP;
        tick();

        // GPIO out write timing and read-back.
        start_req();
        mem_op      = MEM_WRITE;
        mem_rw_addr = 8'hF0;
        mem_wdata   = 8'h3C;
        tick();
        check("gpo_in_access", 32'(gpio_out), 32'h00);
        tick();
        check("gpo_after_access", 32'(gpio_out), 32'h3C);
        check("gpo_ready", 32'(mem_ready), 32'h1);
        mem_op = MEM_NOP;
        repeat (2) tick();
        req(MEM_READ, 8'hF0, 8'h00, 3);
        check("gpo_rd", 32'(cap_rdata), 32'h3C);
        check("gpo_rd_err", 32'(cap_err), 32'h0);

        // GPIO in through the synchronizer.
        gpio_in = 8'h81;
        repeat (3) tick();
        req(MEM_READ, 8'hF1, 8'h00, 3);
        check("gpi_rd", 32'(cap_rdata), 32'h81);
        check("gpi_rd_err", 32'(cap_err), 32'h0);

        // Timer: FE written, read 4 edges later -> FE+4 wraps to 02.
        start_req();
        mem_op      = MEM_WRITE;
        mem_rw_addr = 8'hF2;
        mem_wdata   = 8'hFE;
        repeat (2) tick();
        check("tmr_wr_ready", 32'(mem_ready), 32'h1);
        mem_op = MEM_NOP;
        repeat (3) tick();
        mem_op = MEM_READ;
        tick();
        tick();
        check("tmr_rd_ready", 32'(mem_ready), 32'h1);
        check("tmr_rd_wrap", 32'(mem_rdata), 32'h02);
        mem_op = MEM_NOP;
        tick();

        // Error cases and rdata persistence across writes.
        req(MEM_READ, 8'hA0, 8'h00, 3);
        check("unm_A0_err", 32'(cap_err), 32'h1);
        check("unm_A0_data", 32'(cap_rdata), 32'h00);
        req(MEM_READ, 8'h05, 8'h00, 3);
        check("rd05_again", 32'(cap_rdata), 32'hA5);
        req(MEM_WRITE, 8'hF1, 8'h55, 3);
        check("wr_gpi_err", 32'(cap_err), 32'h1);
        check("wr_keeps_rdata", 32'(mem_rdata), 32'hA5);
        req(MEM_READ, 8'hF1, 8'h00, 3);
        check("gpi_unchanged", 32'(cap_rdata), 32'h81);
        req(MEM_READ, 8'h80, 8'h00, 3);
        check("unm_80_err", 32'(cap_err), 32'h1);
        req(MEM_READ, 8'hF3, 8'h00, 3);
        check("unm_F3_err", 32'(cap_err), 32'h1);
        req(MEM_WRITE, 8'hA0, 8'h12, 3);
        check("unm_wr_err", 32'(cap_err), 32'h1);
        req(MEM_WRITE, 8'h7F, 8'h99, 3);
        check("wr7F_err", 32'(cap_err), 32'h0);
        req(MEM_READ, 8'h7F, 8'h00, 3);
        check("rd7F_data", 32'(cap_rdata), 32'h99);

        // Reset during ACCESS drops the write.
        req(MEM_WRITE, 8'h10, 8'h44, 3);
        start_req();
        mem_op      = MEM_WRITE;
        mem_rw_addr = 8'h10;
        mem_wdata   = 8'h77;
        tick();
        check("rsta_in_access", 32'(dbg_state), 32'(ACCESS));
        reset  = 1'b1;
        mem_op = MEM_NOP;
        tick();
        check("rsta_ready", 32'(mem_ready), 32'h0);
        check("rsta_rdata", 32'(mem_rdata), 32'h00);
        check("rsta_err", 32'(mem_err), 32'h0);
        check("rsta_gpio_out", 32'(gpio_out), 32'h00);
        check("rsta_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        tick();
        check("rsta_no_late_ready", 32'(mem_ready), 32'h0);
        mem_op      = MEM_READ;
        mem_rw_addr = 8'hF2;
        tick();
        tick();
        check("rsta_tmr_ready", 32'(mem_ready), 32'h1);
        check("rsta_tmr_val", 32'(mem_rdata), 32'h02);
        mem_op = MEM_NOP;
        tick();
        req(MEM_READ, 8'h10, 8'h00, 3);
        check("rsta_ram_kept", 32'(cap_rdata), 32'h44);
        check("rsta_readies", 32'(ready_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
